// File: rtl/knn_voter_if.sv
// Port bundle for knn_voter: host label-write port, start/busy/done vote handshake,
// and the sorter slot-readout pair (sel out, idx_in back).
interface knn_voter_if #(
  parameter int K      = 4,
  parameter int SEL_W  = 2,
  parameter int IDX_W  = 8,
  parameter int CLS_W  = 2,
  parameter int VOTE_W = $clog2(K + 1)
);
  logic              label_we;
  logic [IDX_W-1:0]  label_addr;
  logic [CLS_W-1:0]  label_din;
  logic              start;
  logic [SEL_W:0]    nvalid;
  logic [SEL_W-1:0]  sel;
  logic [IDX_W-1:0]  idx_in;
  logic              busy;
  logic              done;
  logic [CLS_W-1:0]  class_out;
  logic [VOTE_W-1:0] votes_out;

  modport master (
    output label_we, label_addr, label_din, start, nvalid, idx_in,
    input  sel, busy, done, class_out, votes_out
  );

  modport slave (
    input  label_we, label_addr, label_din, start, nvalid, idx_in,
    output sel, busy, done, class_out, votes_out
  );
endinterface

// File: rtl/knn_voter.sv
// Majority-vote classifier behind the KNN sorter: walks slots 0..nv-1, looks up labels, votes.
// Optional KNN_VOTE_TIE_NEAREST_EN: ties go to the class of the nearest neighbour, else lowest class.
module knn_voter #(
  parameter int K      = 4,
  parameter int SEL_W  = 2,
  parameter int IDX_W  = 8,
  parameter int NCLASS = 4,
  parameter int CLS_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  knn_voter_if.slave  bus
);
  localparam int VOTE_W = $clog2(K + 1);
  localparam int NV_W   = SEL_W + 1;
  localparam int NSLOT  = 2 ** CLS_W;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DECIDE} state_t;

  state_t            state;
  logic [NV_W-1:0]   nv;
  logic [NV_W-1:0]   nv_in;
  logic [SEL_W-1:0]  sel_q;
  logic              busy_q;
  logic              done_q;
  logic [CLS_W-1:0]  class_q;
  logic [VOTE_W-1:0] votes_q;

  logic [CLS_W-1:0]  mem [2**IDX_W];
  logic [CLS_W-1:0]  lbl_q;
  logic              rd_vld;
  logic [VOTE_W-1:0] vote [NSLOT];
  logic [CLS_W-1:0]  best_cls;
  logic [VOTE_W-1:0] best_votes;
`ifdef KNN_VOTE_TIE_NEAREST_EN
  logic [SEL_W-1:0]  rd_slot;
  logic [SEL_W-1:0]  first_sel [NSLOT];
`endif

  assign nv_in = (int'(bus.nvalid) > K) ? NV_W'(K) : bus.nvalid;

  // Label store is deliberately left out of reset; host reloads it as needed.
  always_ff @(posedge clk) begin
    if (bus.label_we && state == IDLE)
      mem[bus.label_addr] <= bus.label_din;
    lbl_q <= mem[bus.idx_in];
  end

  always_comb begin
    best_cls   = '0;
    best_votes = vote[0];
    for (int c = 1; c < NCLASS; c++) begin
      if (vote[c] > best_votes) begin
        best_cls   = CLS_W'(c);
        best_votes = vote[c];
      end
`ifdef KNN_VOTE_TIE_NEAREST_EN
      else if (vote[c] == best_votes && best_votes != '0 &&
               first_sel[c] < first_sel[best_cls]) begin
        best_cls = CLS_W'(c);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      nv      <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      class_q <= '0;
      votes_q <= '0;
      rd_vld  <= 1'b0;
      for (int c = 0; c < NSLOT; c++) vote[c] <= '0;
`ifdef KNN_VOTE_TIE_NEAREST_EN
      rd_slot <= '0;
      for (int c = 0; c < NSLOT; c++) first_sel[c] <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      rd_vld <= (state == FETCH);
`ifdef KNN_VOTE_TIE_NEAREST_EN
      rd_slot <= sel_q;
`endif
      // Label of the previous slot lands here; out-of-range classes are dropped.
      if (rd_vld && int'(lbl_q) < NCLASS) begin
        if (vote[lbl_q] != VOTE_W'(K))
          vote[lbl_q] <= vote[lbl_q] + 1'b1;
`ifdef KNN_VOTE_TIE_NEAREST_EN
        if (vote[lbl_q] == '0)
          first_sel[lbl_q] <= rd_slot;
`endif
      end

      case (state)
        IDLE: begin
          sel_q <= '0;
          if (bus.start) begin
            nv     <= nv_in;
            busy_q <= 1'b1;
            for (int c = 0; c < NSLOT; c++) vote[c] <= '0;
`ifdef KNN_VOTE_TIE_NEAREST_EN
            for (int c = 0; c < NSLOT; c++) first_sel[c] <= '0;
`endif
            state <= (nv_in == '0) ? DECIDE : FETCH;
          end
        end
        FETCH: begin
          if ({1'b0, sel_q} == nv - 1'b1) begin
            sel_q <= '0;
            state <= DRAIN;
          end else begin
            sel_q <= sel_q + 1'b1;
          end
        end
        DRAIN: state <= DECIDE;
        DECIDE: begin
          class_q <= best_cls;
          votes_q <= best_votes;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.class_out = class_q;
  assign bus.votes_out = votes_q;
endmodule

// File: tb/tb_knn_voter.sv
// Scoreboard bench for knn_voter: a default NCLASS=4 instance plus an NCLASS=3 instance on shared stimulus.
`timescale 1ns/1ps
module tb_knn_voter;
  localparam int K = 4, SEL_W = 2, IDX_W = 8, CLS_W = 2;

  typedef struct { int cls; int votes; longint t_done; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  knn_voter_if #(.K(K), .SEL_W(SEL_W), .IDX_W(IDX_W), .CLS_W(CLS_W)) vif ();
  knn_voter_if #(.K(K), .SEL_W(SEL_W), .IDX_W(IDX_W), .CLS_W(CLS_W)) vif3 ();

  knn_voter #(.K(K), .SEL_W(SEL_W), .IDX_W(IDX_W), .NCLASS(4), .CLS_W(CLS_W))
    u_dut (.clk(clk), .rst(rst), .bus(vif.slave));
  knn_voter #(.K(K), .SEL_W(SEL_W), .IDX_W(IDX_W), .NCLASS(3), .CLS_W(CLS_W))
    u_dut3 (.clk(clk), .rst(rst), .bus(vif3.slave));

  logic [IDX_W-1:0] slot_idx [4];
  int   label_model [256];
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q4[$];
  exp_t q3[$];
  exp_t e4, e3;
  bit   log_en = 1'b0;
  int   sel_log[$];

  // Sorter model: combinational index per slot.
  assign vif.idx_in      = slot_idx[vif.sel];
  assign vif3.idx_in     = slot_idx[vif3.sel];
  assign vif3.label_we   = vif.label_we;
  assign vif3.label_addr = vif.label_addr;
  assign vif3.label_din  = vif.label_din;
  assign vif3.start      = vif.start;
  assign vif3.nvalid     = vif.nvalid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int nvr, input int ncls, input longint t_raise);
    exp_t r;
    int cnt [16];
    int nv, mx, l;
    nv = (nvr > K) ? K : nvr;
    foreach (cnt[c]) cnt[c] = 0;
    mx = 0;
    for (int s = 0; s < nv; s++) begin
      l = label_model[slot_idx[s]];
      if (l < ncls) begin
        cnt[l]++;
        if (cnt[l] > mx) mx = cnt[l];
      end
    end
    r.cls   = 0;
    r.votes = mx;
    if (mx > 0) begin
`ifdef KNN_VOTE_TIE_NEAREST_EN
      for (int s = nv - 1; s >= 0; s--) begin
        l = label_model[slot_idx[s]];
        if (l < ncls && cnt[l] == mx) r.cls = l;
      end
`else
      for (int c = ncls - 1; c >= 0; c--)
        if (cnt[c] == mx) r.cls = c;
`endif
    end
    // start raised 1ns after an edge; done seen at the falling edge of its cycle
    r.t_done = t_raise + 10 * ((nv == 0) ? 2 : nv + 3) + 4;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (vif.busy && log_en) sel_log.push_back(int'(vif.sel));
      if (vif.done) begin
        check("u4_done_expected", q4.size() > 0, 1);
        check("u4_busy_at_done", vif.busy, 0);
        if (q4.size() > 0) begin
          e4 = q4.pop_front();
          check("u4_class", vif.class_out, e4.cls);
          check("u4_votes", vif.votes_out, e4.votes);
          check("u4_done_time", $time, e4.t_done);
        end
      end
      if (vif3.done) begin
        check("u3_done_expected", q3.size() > 0, 1);
        if (q3.size() > 0) begin
          e3 = q3.pop_front();
          check("u3_class", vif3.class_out, e3.cls);
          check("u3_votes", vif3.votes_out, e3.votes);
          check("u3_done_time", $time, e3.t_done);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_label(input int a, input int d);
    vif.label_we   = 1'b1;
    vif.label_addr = a[IDX_W-1:0];
    vif.label_din  = d[CLS_W-1:0];
    tick();
    vif.label_we   = 1'b0;
    label_model[a] = d;
  endtask

  task automatic launch(input int nvr, input int i0, input int i1, input int i2, input int i3);
    slot_idx[0] = i0[IDX_W-1:0];
    slot_idx[1] = i1[IDX_W-1:0];
    slot_idx[2] = i2[IDX_W-1:0];
    slot_idx[3] = i3[IDX_W-1:0];
    vif.nvalid  = nvr[SEL_W:0];
    vif.start   = 1'b1;
    q4.push_back(model(nvr, 4, $time));
    q3.push_back(model(nvr, 3, $time));
    tick();
    vif.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((q4.size() != 0 || q3.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_completed"}, q4.size() + q3.size(), 0);
    q4.delete();
    q3.delete();
  endtask

  task automatic check_sel_walk(input string tag);
    check({tag, "_busy_cycles"}, sel_log.size(), 6);
    for (int i = 0; i < 4; i++)
      if (i < sel_log.size()) check({tag, "_sel"}, sel_log[i], i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vif.label_we = 1'b0; vif.label_addr = '0; vif.label_din = '0;
    vif.start = 1'b0; vif.nvalid = '0;
    foreach (slot_idx[i]) slot_idx[i] = '0;
    foreach (label_model[i]) label_model[i] = 0;
    tick(); tick();
    check("rst_busy", vif.busy, 0);
    check("rst_done", vif.done, 0);
    check("rst_class", vif.class_out, 0);
    check("rst_votes", vif.votes_out, 0);
    check("rst_sel", vif.sel, 0);
    rst = 1'b0;
    tick();

    write_label(10, 1); write_label(20, 1); write_label(30, 2); write_label(40, 1);
    write_label(50, 3); write_label(60, 0); write_label(70, 0); write_label(80, 3);
    write_label(90, 3);

    // Majority with sel walk
    sel_log.delete(); log_en = 1'b1;
    launch(4, 10, 20, 30, 40);
    wait_done("majority");
    log_en = 1'b0;
    check_sel_walk("majority");

    launch(4, 50, 60, 70, 80);
    wait_done("tie");

    launch(0, 10, 20, 30, 40);
    wait_done("empty");

    sel_log.delete(); log_en = 1'b1;
    launch(7, 60, 20, 50, 10);
    wait_done("clamp");
    log_en = 1'b0;
    check_sel_walk("clamp");

    // start re-pulsed while busy must be ignored
    launch(4, 10, 20, 30, 40);
    tick();
    vif.start = 1'b1; vif.nvalid = '0;
    tick();
    vif.start = 1'b0;
    wait_done("restart_busy");
    repeat (8) tick();

    // label write while busy must not land
    launch(4, 10, 20, 30, 40);
    vif.label_we = 1'b1; vif.label_addr = 8'd10; vif.label_din = 2'd2;
    tick(); tick();
    vif.label_we = 1'b0;
    wait_done("we_busy");
    launch(4, 10, 20, 30, 40);
    wait_done("we_readback");

    // start in the done cycle
    launch(2, 30, 60, 0, 0);
    for (int n = 0; n < 20 && !vif.done; n++) tick();
    check("coinc_done_seen", vif.done, 1);
    launch(4, 50, 60, 70, 80);
    wait_done("coincident");

    // async reset mid-FETCH
    launch(4, 50, 80, 90, 10);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", vif.busy, 0);
    check("midrst_done", vif.done, 0);
    check("midrst_class", vif.class_out, 0);
    check("midrst_votes", vif.votes_out, 0);
    q4.delete(); q3.delete();
    tick();
    rst = 1'b0;
    tick();
    launch(4, 50, 80, 90, 10);
    wait_done("after_reset");

    launch(4, 80, 10, 20, 30);
    wait_done("out_of_range");

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
